// File: rtl/dev_reshuffler_packer_if.sv
// Narrow-in / wide-out stream bundle for the reshuffler packer.
// master: the side that feeds narrow beats and consumes wide words.
// slave:  the packer itself.
interface dev_reshuffler_packer_if #(
    parameter int unsigned SpatPar   = 8,
    parameter int unsigned DataWidth = 64
);
    localparam int unsigned BeatW = $clog2(SpatPar) + 1;
    localparam int unsigned WideW = SpatPar * DataWidth;

    logic [DataWidth-1:0] a;
    logic                 a_valid;
    logic                 a_last;
    logic                 a_ready;

    logic [WideW-1:0]     z;
    logic [BeatW-1:0]     z_beats;
    logic                 z_valid;
    logic                 z_ready;

    modport master (
        output a, a_valid, a_last, z_ready,
        input  a_ready, z, z_beats, z_valid
    );

    modport slave (
        input  a, a_valid, a_last, z_ready,
        output a_ready, z, z_beats, z_valid
    );
endinterface

// File: rtl/dev_reshuffler_packer.sv
// Packs SpatPar narrow beats into one wide word for the reshuffler.
// A fill buffer collects beats lane by lane; a completed word moves into a
// registered output stage, so the buffer can start the next word in the same
// cycle and one beat per cycle is sustained without backpressure.
module dev_reshuffler_packer #(
    parameter int unsigned SpatPar   = 8,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned BeatW     = $clog2(SpatPar) + 1
) (
    input logic               clk_i,
    input logic               rst_ni,
    dev_reshuffler_packer_if.slave bus
);
    localparam int unsigned WideW = SpatPar * DataWidth;

    logic [WideW-1:0] fill_data_q, fill_data_d;
    logic [BeatW-1:0] fill_cnt_q,  fill_cnt_d;
    logic             fill_full_q, fill_full_d;

    logic [WideW-1:0] out_data_q,  out_data_d;
    logic [BeatW-1:0] out_beats_q, out_beats_d;
    logic             out_valid_q, out_valid_d;

    logic             move;
    logic             a_ready;
    logic             acc;

    // Handshake decode: ready depends only on state and downstream ready.
    always_comb begin
        move    = fill_full_q && (!out_valid_q || bus.z_ready);
        a_ready = !fill_full_q || move;
        acc     = bus.a_valid && a_ready;
    end

    // Fill buffer next state: a move clears it, an accept writes the next lane
    // (lane 0 of the cleared buffer when both happen together).
    always_comb begin
        logic [WideW-1:0] base_data;
        logic [BeatW-1:0] base_cnt;

        fill_data_d = fill_data_q;
        fill_cnt_d  = fill_cnt_q;
        fill_full_d = fill_full_q;
        base_data   = fill_data_q;
        base_cnt    = fill_cnt_q;

        if (move) begin
            fill_data_d = '0;
            fill_cnt_d  = '0;
            fill_full_d = 1'b0;
            base_data   = '0;
            base_cnt    = '0;
        end

        if (acc) begin
            fill_data_d = base_data;
            for (int k = 0; k < int'(SpatPar); k++) begin
                if (base_cnt == BeatW'(k)) begin
                    fill_data_d[k*DataWidth +: DataWidth] = bus.a;
                end
            end
            fill_cnt_d  = base_cnt + BeatW'(1);
            fill_full_d = (fill_cnt_d == BeatW'(SpatPar)) || bus.a_last;
        end
    end

    // Output register next state: a move loads the new word and wins over a
    // drain; a drain zeroes the data so the bus is quiet while idle.
    always_comb begin
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q;

        if (move) begin
            out_data_d  = fill_data_q;
            out_beats_d = fill_cnt_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.z_ready) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_data_q <= '0;
            fill_cnt_q  <= '0;
            fill_full_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_data_q <= fill_data_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_full_q <= fill_full_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.a_ready = a_ready;
    assign bus.z       = out_data_q;
    assign bus.z_beats = out_beats_q;
    assign bus.z_valid = out_valid_q;

endmodule

// File: tb/tb_dev_reshuffler_packer.sv
// Bench for dev_reshuffler_packer: directed scenarios plus a randomized run,
// all checked against a queue-based word-packing model.
module tb_dev_reshuffler_packer;
    localparam int SP = 8;
    localparam int DW = 64;
    localparam int WW = SP * DW;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    dev_reshuffler_packer_if #(.SpatPar(SP), .DataWidth(DW)) bus ();

    dev_reshuffler_packer #(.SpatPar(SP), .DataWidth(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] cur[$];
    logic [WW-1:0] exp_data[$];
    int            exp_beats[$];
    int            hs_cyc[$];

    logic          prev_stall;
    logic [WW-1:0] prev_data;
    logic [3:0]    prev_beats;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and output monitor, sampled mid-cycle.
    initial begin
        logic [WW-1:0] w;
        logic [WW-1:0] ed;
        int            eb;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_beats = '0;
        forever begin
            @(negedge clk);
            if (rst_ni !== 1'b1) begin
                cur.delete();
                exp_data.delete();
                exp_beats.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (bus.z_valid !== 1'b1 || bus.z !== prev_data || bus.z_beats !== prev_beats) begin
                        n_fail++;
                        $display("FAIL hold: valid=%0b beats=%0d z=%h, required valid=1 beats=%0d z=%h",
                                 bus.z_valid, bus.z_beats, bus.z, prev_beats, prev_data);
                    end
                end
                if (bus.z_valid === 1'b1 && bus.z_ready === 1'b1) begin
                    hs_cyc.push_back(cyc);
                    n_checks++;
                    if (exp_data.size() == 0) begin
                        n_fail++;
                        $display("FAIL word: unexpected word beats=%0d z=%h, required none", bus.z_beats, bus.z);
                    end else begin
                        ed = exp_data.pop_front();
                        eb = exp_beats.pop_front();
                        if (bus.z !== ed || bus.z_beats !== 4'(eb)) begin
                            n_fail++;
                            $display("FAIL word: beats=%0d z=%h, required beats=%0d z=%h",
                                     bus.z_beats, bus.z, eb, ed);
                        end
                    end
                end
                prev_stall = (bus.z_valid === 1'b1) && (bus.z_ready !== 1'b1);
                prev_data  = bus.z;
                prev_beats = bus.z_beats;
                if (bus.a_valid === 1'b1 && bus.a_ready === 1'b1) begin
                    cur.push_back(bus.a);
                    if (cur.size() == SP || bus.a_last === 1'b1) begin
                        w = '0;
                        foreach (cur[k]) w[k*DW +: DW] = cur[k];
                        exp_data.push_back(w);
                        exp_beats.push_back(cur.size());
                        cur.delete();
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        bit done = 0;
        bus.a       = d;
        bus.a_last  = last;
        bus.a_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.a_ready === 1'b1) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: a_ready stayed low, required a beat to be accepted");
        end
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        bus.a       = '0;
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
        bus.z_ready = 1'b1;
        #23;
        n_checks++;
        if (bus.z !== '0 || bus.z_beats !== 4'd0 || bus.z_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%0b beats=%0d z=%h, required all zero", bus.z_valid, bus.z_beats, bus.z);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: a_ready=%0b, required 1", bus.a_ready);
        end
    endtask

    task automatic test_single_word();
        logic [WW-1:0] w = '0;
        bus.z_ready = 1'b1;
        for (int k = 0; k < SP; k++) begin
            w[k*DW +: DW] = DW'(8'h10 + k);
            send_beat(DW'(8'h10 + k), 1'b0);
        end
        n_checks++;
        if (bus.z_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: z_valid=%0b right after last accept, required 0", bus.z_valid);
        end
        wait_cycles(1);
        n_checks++;
        if (bus.z_valid !== 1'b1 || bus.z_beats !== 4'd8 || bus.z !== w) begin
            n_fail++;
            $display("FAIL single_word: valid=%0b beats=%0d z=%h, required valid=1 beats=8 z=%h",
                     bus.z_valid, bus.z_beats, bus.z, w);
        end
        wait_cycles(1);
        n_checks++;
        if (bus.z_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: z_valid=%0b after one cycle, required 0", bus.z_valid);
        end
    endtask

    task automatic test_stream();
        bus.z_ready = 1'b1;
        hs_cyc.delete();
        bus.a_valid = 1'b1;
        bus.a_last  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.a = {$urandom, $urandom};
            @(negedge clk);
            n_checks++;
            if (bus.a_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready: beat %0d a_ready=%0b, required 1", i, bus.a_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.a_valid = 1'b0;
        wait_cycles(12);
        n_checks++;
        if (hs_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL stream_count: words=%0d, required 4", hs_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (hs_cyc[i] - hs_cyc[i-1] != SP) begin
                    n_fail++;
                    $display("FAIL stream_spacing: gap=%0d, required %0d", hs_cyc[i] - hs_cyc[i-1], SP);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w0 = '0;
        logic [WW-1:0] w1 = '0;
        logic [DW-1:0] d;
        bus.z_ready = 1'b0;
        for (int i = 0; i < 2*SP; i++) begin
            d = {$urandom, $urandom};
            if (i < SP) w0[i*DW +: DW] = d;
            else        w1[(i-SP)*DW +: DW] = d;
            send_beat(d, 1'b0);
        end
        n_checks++;
        if (bus.a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_low: a_ready=%0b after 16 beats, required 0", bus.a_ready);
        end
        wait_cycles(3);
        n_checks++;
        if (bus.z_valid !== 1'b1 || bus.z !== w0 || bus.a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_word0: valid=%0b ready=%0b z=%h, required valid=1 ready=0 z=%h",
                     bus.z_valid, bus.a_ready, bus.z, w0);
        end
        bus.z_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_rise: a_ready=%0b, required 1", bus.a_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.z_valid !== 1'b1 || bus.z !== w1 || bus.z_beats !== 4'd8) begin
            n_fail++;
            $display("FAIL bp_word1: valid=%0b beats=%0d z=%h, required valid=1 beats=8 z=%h",
                     bus.z_valid, bus.z_beats, bus.z, w1);
        end
        wait_cycles(3);
    endtask

    task automatic test_partial();
        logic [DW-1:0] lanes[3];
        bit seen = 0;
        lanes[0] = 64'hA;
        lanes[1] = 64'hB;
        lanes[2] = 64'hC;
        bus.z_ready = 1'b1;
        send_beat(lanes[0], 1'b0);
        send_beat(lanes[1], 1'b0);
        send_beat(lanes[2], 1'b1);
        for (int t = 0; t < 20 && !seen; t++) begin
            if (bus.z_valid === 1'b1) begin
                seen = 1;
                n_checks++;
                if (bus.z_beats !== 4'd3 || bus.z[WW-1:3*DW] !== '0) begin
                    n_fail++;
                    $display("FAIL partial_pad: beats=%0d z=%h, required beats=3 upper lanes zero", bus.z_beats, bus.z);
                end
                for (int k = 0; k < 3; k++) begin
                    n_checks++;
                    if (bus.z[k*DW +: DW] !== lanes[k]) begin
                        n_fail++;
                        $display("FAIL partial_lane%0d: %h, required %h", k, bus.z[k*DW +: DW], lanes[k]);
                    end
                end
            end else wait_cycles(1);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL partial_timeout: no word seen, required one");
        end
        for (int i = 0; i < SP; i++) send_beat({$urandom, $urandom}, 1'b0);
        wait_cycles(4);
    endtask

    task automatic test_last_on_full();
        int vcount = 0;
        bus.z_ready = 1'b1;
        hs_cyc.delete();
        for (int i = 0; i < SP; i++) send_beat({$urandom, $urandom}, i == SP - 1);
        wait_cycles(3);
        bus.a_last = 1'b1;
        wait_cycles(1);
        bus.a_last = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.z_valid === 1'b1) vcount++;
            wait_cycles(1);
        end
        n_checks++;
        if (hs_cyc.size() != 1 || vcount != 0) begin
            n_fail++;
            $display("FAIL last_full: words=%0d extra_valid=%0d, required words=1 extra_valid=0", hs_cyc.size(), vcount);
        end
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] w = '0;
        logic [DW-1:0] d;
        bus.z_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.z_valid !== 1'b0 || bus.z !== '0 || bus.z_beats !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_fill: valid=%0b beats=%0d z=%h, required all zero", bus.z_valid, bus.z_beats, bus.z);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < SP; i++) begin
            d = {$urandom, $urandom};
            w[i*DW +: DW] = d;
            send_beat(d, 1'b0);
        end
        wait_cycles(1);
        n_checks++;
        if (bus.z_valid !== 1'b1 || bus.z !== w || bus.z_beats !== 4'd8) begin
            n_fail++;
            $display("FAIL rst_repack: valid=%0b beats=%0d z=%h, required valid=1 beats=8 z=%h",
                     bus.z_valid, bus.z_beats, bus.z, w);
        end
        wait_cycles(2);
        bus.z_ready = 1'b0;
        for (int i = 0; i < SP; i++) send_beat({$urandom, $urandom}, 1'b0);
        wait_cycles(2);
        n_checks++;
        if (bus.z_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall_setup: z_valid=%0b, required 1", bus.z_valid);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.z_valid !== 1'b0 || bus.z !== '0 || bus.z_beats !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_stall: valid=%0b beats=%0d z=%h, required all zero", bus.z_valid, bus.z_beats, bus.z);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        bus.z_ready = 1'b1;
        wait_cycles(4);
        n_checks++;
        if (bus.z_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flush: z_valid=%0b after release, required 0", bus.z_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.a_valid = ($urandom_range(3, 0) != 0);
            bus.a       = {$urandom, $urandom};
            bus.a_last  = ($urandom_range(5, 0) == 0);
            bus.z_ready = ($urandom_range(2, 0) != 0);
            wait_cycles(1);
        end
        bus.a_valid = 1'b0;
        bus.a_last  = 1'b0;
        bus.z_ready = 1'b1;
        send_beat({$urandom, $urandom}, 1'b1);
        wait_cycles(20);
        n_checks++;
        if (exp_data.size() != 0 || cur.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: pending_words=%0d pending_beats=%0d, required 0 and 0",
                     exp_data.size(), cur.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_partial();
        test_last_on_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
